junction_phase_scheduler: RTL and testbench
===========================================

Name: junction_phase_scheduler

Overview:
- Demand-actuated scheduler for a 4-phase junction. It grants green to one phase at a time, chosen round-robin from vehicle-presence requests.
- Enforces min/max green, yellow and all-red clearance timing. Supports emergency preemption.
- Sits above the per-phase light drivers and replaces fixed-cycle sequencing. All timing is counted in `tick` pulses from the junction's 1 Hz prescaler.

Parameters:
- GREEN_MIN, 4, minimum green duration in ticks (>=1)
- GREEN_MAX, 10, maximum green duration in ticks when conflicting demand exists (>=GREEN_MIN)
- YELLOW_T, 2, yellow duration in ticks (>=1)
- ALLRED_T, 1, all-red clearance duration in ticks (>=1)
- CW, 4, counter width; must hold GREEN_MAX-1

Ports:
- clk, input, 1, system clock
- rst, input, 1, synchronous active-high reset
- tick, input, 1, one-cycle timing enable; timers advance only when high
- req, input, 4, level vehicle-presence request per phase (bit n = phase n)
- emg_req, input, 1, emergency preemption request (level)
- emg_phase, input, 2, phase to serve under emergency
- light_bus, output, 12, 3 bits per phase at [3n+2:3n]; 100 = red, 010 = yellow, 001 = green
- ps, output, 2, state: 0 = ALL_RED, 1 = GREEN, 2 = YELLOW
- count, output, CW, tick counter within the current state
- active, output, 2, currently or last served phase
- emg_ack, output, 1, emergency being served

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous, active-high, and wins over all other inputs, including `tick`.
- Reset values: ps = ALL_RED, count = 0, active = 0, last = 3 (so phase 0 has first priority), emg_ack = 0, light_bus = 12'b100100100100.
- Reset mid-operation: all-red is shown on the clock after `rst` is sampled. No yellow is inserted.
- Registers: ps, count, active and last are registered.
- Outputs: light_bus and emg_ack decode combinationally from ps, active, emg_req and emg_phase, with no extra latency.
  - Decode: GREEN gives phase `active` = 001, others 100. YELLOW gives phase `active` = 010, others 100. ALL_RED gives all phases 100.
  - emg_ack = (ps == GREEN) & emg_req & (active == emg_phase).
- Counter rule:
  - count clears to 0 on every state entry.
  - With tick = 0, count and ps hold.
  - A state of duration N exits on the tick where count == N-1; otherwise count increments on tick.
- Selection (evaluated on the deciding tick):
  - If emg_req, the target is emg_phase, whether or not it is requesting.
  - Else the target is the first set bit of req searching (last+1), (last+2), ... mod 4.
  - Current req levels are used with no latching.
- ALL_RED:
  - On a tick with count >= ALLRED_T-1 and (emg_req | (req != 0)): go to GREEN, active = target, last = target.
  - Otherwise count increments on tick, saturating at ALLRED_T-1.
  - With no demand, rest in all-red.
- GREEN: define other = req with bit `active` cleared. Evaluate on each tick in this priority order:
  1. emg_req & emg_phase != active: go to YELLOW on this tick; min green is ignored.
  2. emg_req & emg_phase == active: hold green; count saturates at GREEN_MAX-1; max-out is disabled.
  3. other != 0 & ((!req[active] & count >= GREEN_MIN-1) | count >= GREEN_MAX-1): go to YELLOW.
  4. Otherwise stay in GREEN; count increments, saturating at GREEN_MAX-1 (rest-in-green when there is no conflicting demand).
- YELLOW: lasts YELLOW_T ticks, then ALL_RED. It is never aborted; emergency waits for it to finish.
- Emergency details:
  - emg_phase changing while an emergency is served is treated as preemption of the current green.
  - emg_req falling returns to normal rules on the next tick. Since count is saturated, a max-out with pending demand is immediate.
- Invariant: at most one phase is non-red at any cycle. The bench must assert this every cycle.

Test Plan:
- Defaults and tick = 1 every cycle are assumed unless a scenario states otherwise.
- 1. rst for 2 cycles, then req = 0001 -> ps = 0 for 1 cycle, then GREEN with active = 0 and light_bus = 100100100001; stays green indefinitely, count saturating at 9.
- 2. req = 0011 held from reset -> phase 0 green for 10 ticks, yellow for 2 (light_bus[2:0] = 010), all-red for 1, then phase 1 green with last = 1.
- 3. req = 0011, req[0] dropped at GREEN count 1 -> phase 0 exits on the tick at count 3 (4-tick green), then yellow 2, all-red 1, phase 1 green.
- 4. Phase 0 green at count 1, assert emg_req with emg_phase = 2 -> YELLOW next cycle, then all-red 1, then phase 2 green with emg_ack = 1. Green holds for more than 10 ticks while emg_req is high despite req = 0001. After emg_req drops: yellow on the next tick, then phase 0 green after clearance.
- 5. req = 0000, tick toggling 1 in 3 cycles -> ps stays 0, light_bus = 100100100100, count stays 0. During GREEN with tick = 0 for 20 cycles, count and ps are frozen.
- 6. rst pulsed at YELLOW count 0 -> next cycle ps = 0, count = 0, active = 0, all red. With req = 1000 after release: phase 3 green after 1 all-red tick.

Source files
------------

// File: rtl/junction_phase_scheduler.sv
// Demand-actuated 4-phase junction scheduler: round-robin green selection from
// presence requests, min/max green, yellow and all-red timing, emergency preemption.
module junction_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [3:0]    req,
    input  logic          emg_req,
    input  logic [1:0]    emg_phase,
    output logic [11:0]   light_bus,
    output logic [1:0]    ps,
    output logic [CW-1:0] count,
    output logic [1:0]    active,
    output logic          emg_ack
);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } state_t;

    localparam logic [CW-1:0] GMIN_END = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_END = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_END  = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] RED_END  = CW'(ALLRED_T - 1);

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [1:0]    active_reg;
    logic [1:0]    last_reg;

    logic [1:0]    rr_target;
    logic [1:0]    target;
    logic [3:0]    other;
    logic          demand;
    logic          green_exit;
    logic [CW-1:0] red_count_next;
    logic [CW-1:0] green_count_next;

    // Round-robin scan: descending k so the nearest phase after last wins.
    always_comb begin
        rr_target = last_reg;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_reg + 2'(k)]) begin
                rr_target = last_reg + 2'(k);
            end
        end
        target = emg_req ? emg_phase : rr_target;
    end

    always_comb begin
        other            = req & ~(4'b0001 << active_reg);
        demand           = emg_req | (req != 4'b0000);
        green_exit       = (other != 4'b0000) &&
                           ((!req[active_reg] && count_reg >= GMIN_END) ||
                            count_reg >= GMAX_END);
        red_count_next   = (count_reg >= RED_END)  ? RED_END  : count_reg + 1'b1;
        green_count_next = (count_reg >= GMAX_END) ? GMAX_END : count_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_ALL_RED;
            count_reg  <= '0;
            active_reg <= 2'd0;
            last_reg   <= 2'd3;
        end else if (tick) begin
            case (state_reg)
                ST_ALL_RED: begin
                    if (count_reg >= RED_END && demand) begin
                        state_reg  <= ST_GREEN;
                        count_reg  <= '0;
                        active_reg <= target;
                        last_reg   <= target;
                    end else begin
                        count_reg <= red_count_next;
                    end
                end
                ST_GREEN: begin
                    if (emg_req && emg_phase != active_reg) begin
                        state_reg <= ST_YELLOW;
                        count_reg <= '0;
                    end else if (emg_req) begin
                        count_reg <= green_count_next;
                    end else if (green_exit) begin
                        state_reg <= ST_YELLOW;
                        count_reg <= '0;
                    end else begin
                        count_reg <= green_count_next;
                    end
                end
                ST_YELLOW: begin
                    if (count_reg >= YEL_END) begin
                        state_reg <= ST_ALL_RED;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_ALL_RED;
                    count_reg <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lamp
            always_comb begin
                light_bus[3*gi +: 3] = 3'b100;
                if (active_reg == 2'(gi)) begin
                    if (state_reg == ST_GREEN) begin
                        light_bus[3*gi +: 3] = 3'b001;
                    end else if (state_reg == ST_YELLOW) begin
                        light_bus[3*gi +: 3] = 3'b010;
                    end
                end
            end
        end
    endgenerate

    assign ps      = state_reg;
    assign count   = count_reg;
    assign active  = active_reg;
    assign emg_ack = (state_reg == ST_GREEN) && emg_req && (active_reg == emg_phase);

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Randomized bench for junction_phase_scheduler against a tick-level behavioural model.
module tb_junction_phase_scheduler;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 10;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int CW        = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [3:0]    req = 4'b0000;
    logic          emg_req = 1'b0;
    logic [1:0]    emg_phase = 2'd0;
    logic [11:0]   light_bus;
    logic [1:0]    ps;
    logic [CW-1:0] count;
    logic [1:0]    active;
    logic          emg_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: phase mode (0 red, 1 green, 2 yellow), ticks spent, served phases.
    int m_mode;
    int m_elapsed;
    int m_act;
    int m_last;

    junction_phase_scheduler #(
        .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T),
        .ALLRED_T(ALLRED_T), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .emg_req(emg_req),
        .emg_phase(emg_phase), .light_bus(light_bus), .ps(ps), .count(count),
        .active(active), .emg_ack(emg_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_target();
        int p;
        if (emg_req) return int'(emg_phase);
        for (int k = 1; k <= 4; k++) begin
            p = (m_last + k) % 4;
            if (req[p]) return p;
        end
        return m_last;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v + 1 > lim) ? lim : v + 1;
    endfunction

    task automatic model_step();
        bit others;
        if (rst) begin
            m_mode = 0; m_elapsed = 0; m_act = 0; m_last = 3;
            return;
        end
        if (!tick) return;
        if (m_mode == 0) begin
            if (m_elapsed >= ALLRED_T - 1 && (emg_req || req != 0)) begin
                m_act = pick_target(); m_last = m_act;
                m_mode = 1; m_elapsed = 0;
            end else begin
                m_elapsed = sat(m_elapsed, ALLRED_T - 1);
            end
        end else if (m_mode == 1) begin
            others = 1'b0;
            for (int p = 0; p < 4; p++) if (p != m_act && req[p]) others = 1'b1;
            if (emg_req && int'(emg_phase) != m_act) begin
                m_mode = 2; m_elapsed = 0;
            end else if (emg_req) begin
                m_elapsed = sat(m_elapsed, GREEN_MAX - 1);
            end else if (others && ((!req[m_act] && m_elapsed >= GREEN_MIN - 1) ||
                                    m_elapsed >= GREEN_MAX - 1)) begin
                m_mode = 2; m_elapsed = 0;
            end else begin
                m_elapsed = sat(m_elapsed, GREEN_MAX - 1);
            end
        end else begin
            if (m_elapsed == YELLOW_T - 1) begin
                m_mode = 0; m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [11:0] exp_lb;
        int nonred;
        exp_lb = 12'b100100100100;
        for (int p = 0; p < 4; p++) begin
            if (p == m_act && m_mode == 1) exp_lb[3*p +: 3] = 3'b001;
            if (p == m_act && m_mode == 2) exp_lb[3*p +: 3] = 3'b010;
        end
        nonred = 0;
        for (int p = 0; p < 4; p++) if (light_bus[3*p +: 3] != 3'b100) nonred++;
        check_eq("ps", 32'(ps), 32'(m_mode));
        check_eq("count", 32'(count), 32'(m_elapsed));
        check_eq("active", 32'(active), 32'(m_act));
        check_eq("light_bus", 32'(light_bus), 32'(exp_lb));
        check_eq("emg_ack", 32'(emg_ack),
                 32'(m_mode == 1 && emg_req && int'(emg_phase) == m_act));
        check_eq("one_nonred", 32'(nonred <= 1), 32'd1);
    endtask

    // Per-segment stimulus profile (percent / per-mille probabilities).
    int tick_pct [6] = '{100, 100, 33, 60, 100, 80};
    int req_flip [6] = '{6,   4,   8,  0,  3,   15};
    int emg_flip [6] = '{0,   2,   1,  0,  3,   4};
    int rst_pm   [6] = '{0,   3,   0,  2,  4,   8};

    initial begin
        m_mode = 0; m_elapsed = 0; m_act = 0; m_last = 3;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); model_step();
            @(negedge clk); compare_outputs();
        end
        rst = 1'b0;
        for (int seg = 0; seg < 6; seg++) begin
            if (req_flip[seg] == 0) req = 4'b0000;
            if (emg_flip[seg] == 0) emg_req = 1'b0;
            for (int c = 0; c < 700; c++) begin
                tick = ($urandom_range(99) < tick_pct[seg]);
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(99) < req_flip[seg]) req[b] = ~req[b];
                if ($urandom_range(99) < emg_flip[seg]) emg_req = ~emg_req;
                if ($urandom_range(99) < 5) emg_phase = 2'($urandom_range(3));
                rst = ($urandom_range(999) < rst_pm[seg]);
                @(posedge clk); model_step();
                @(negedge clk); compare_outputs();
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
